nn_udiv_16ns_9ns_8_seq: RTL

NN_UDIV_16NS_9NS_8_SEQ -- requirements
Module: nn_udiv_16ns_9ns_8_seq

---
 rtl/nn_udiv_16ns_9ns_8_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nn_udiv_16ns_9ns_8_seq.sv
// ---------------------------------------------------------------------------
// nn_udiv_16ns_9ns_8_seq
//
// Sequential unsigned divider: din0 / din1 using restoring division, one
// quotient bit per clock, MSB first. The quotient presented on dout is
// saturated to dout_WIDTH bits and flagged with ovf. A zero divisor skips
// the iteration phase entirely and reports dbz.
//
// Build option:
//   NN_UDIV_REM_EN  defined   -> rem carries the true remainder.
//                   undefined -> rem is tied to zero (no output register).
//
// Handshake (ap_* protocol):
//   - ap_start is sampled only while ap_idle is high. If it is high on a
//     rising edge in IDLE the operands are captured on that same edge
//     (the accepting edge); din0/din1/ap_start are ignored at all other
//     times.
//   - ap_done and ap_ready pulse together for exactly one cycle; dout,
//     rem, ovf and dbz are valid from that cycle and held until the next
//     result is produced.
//   - Holding ap_start high restarts in the IDLE cycle after DONE, giving
//     one result every din0_WIDTH+2 cycles.
//
// Ports:
//   ap_clk    in   clock, rising edge
//   ap_rst_n  in   asynchronous active-low reset
//   ap_start  in   request
//   din0      in   dividend  [din0_WIDTH-1:0]
//   din1      in   divisor   [din1_WIDTH-1:0]
//   ap_idle   out  high while in IDLE (combinational from state)
//   ap_done   out  one-cycle result-valid pulse
//   ap_ready  out  one-cycle pulse, same cycle as ap_done
//   dout      out  saturated quotient [dout_WIDTH-1:0]
//   rem       out  remainder [din1_WIDTH-1:0]
//   ovf       out  full quotient did not fit in dout_WIDTH bits
//   dbz       out  divisor was zero
// ---------------------------------------------------------------------------
module nn_udiv_16ns_9ns_8_seq #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CNT_W = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(din0_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;     // iteration index within CALC
    // Dividend bits shift out of the MSB while quotient bits shift in at the
    // LSB, so one register holds both; after the last step it is the full
    // din0_WIDTH-bit quotient.
    logic [din0_WIDTH-1:0]   quo_q;
    logic [din1_WIDTH:0]     prem_q;    // partial remainder
    logic [din1_WIDTH-1:0]   dvs_q;     // latched divisor
    logic [dout_WIDTH-1:0]   dout_q;
    logic                    ovf_q;
    logic                    dbz_q;
    logic                    done_q;

    // One restoring step.
    logic [din1_WIDTH:0]     prem_shift;
    logic [din1_WIDTH:0]     prem_sub;
    logic [din1_WIDTH:0]     prem_d;
    logic                    step_ge;
    logic [din0_WIDTH-1:0]   quo_d;
    logic                    quo_ovf;
    logic [dout_WIDTH-1:0]   quo_sat;

    always_comb begin
        prem_shift = {prem_q[din1_WIDTH-1:0], quo_q[din0_WIDTH-1]};
        prem_sub   = prem_shift - {1'b0, dvs_q};
        step_ge    = (prem_shift >= {1'b0, dvs_q});
        prem_d     = step_ge ? prem_sub : prem_shift;
        quo_d      = {quo_q[din0_WIDTH-2:0], step_ge};
        // Any set bit above the dout field means the quotient saturates.
        quo_ovf    = |quo_d[din0_WIDTH-1:dout_WIDTH];
        quo_sat    = quo_ovf ? {dout_WIDTH{1'b1}} : quo_d[dout_WIDTH-1:0];
    end

    // The stored partial remainder is always below the divisor, so its top
    // bit is never set and never needed for the next shift.
    logic unused_prem_msb;
    assign unused_prem_msb = prem_q[din1_WIDTH];

`ifdef NN_UDIV_REM_EN
    logic [din1_WIDTH-1:0]   rem_q;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef NN_UDIV_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        if (din1 == '0) begin
                            // Divide by zero: result is fixed, go straight
                            // to DONE.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            dout_q  <= '1;
                            ovf_q   <= 1'b0;
                            dbz_q   <= 1'b1;
`ifdef NN_UDIV_REM_EN
                            rem_q   <= '0;
`endif
                        end else begin
                            state_q <= S_CALC;
                            quo_q   <= din0;
                            prem_q  <= '0;
                            dvs_q   <= din1;
                            cnt_q   <= '0;
                        end
                    end
                end

                S_CALC: begin
                    quo_q  <= quo_d;
                    prem_q <= prem_d;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        dout_q  <= quo_sat;
                        ovf_q   <= quo_ovf;
                        dbz_q   <= 1'b0;
`ifdef NN_UDIV_REM_EN
                        rem_q   <= prem_d[din1_WIDTH-1:0];
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_idle  = (state_q == S_IDLE);
    assign ap_done  = done_q;
    assign ap_ready = done_q;
    assign dout     = dout_q;
    assign ovf      = ovf_q;
    assign dbz      = dbz_q;

`ifdef NN_UDIV_REM_EN
    assign rem      = rem_q;
`else
    assign rem      = '0;
`endif

endmodule
